axi_probe_ram: RTL and testbench



---
 rtl/axi_probe_pkg.sv | 36 +++
 rtl/sdp_ram.sv | 37 +++
 rtl/axi_probe_ram.sv | 198 +++++++++++++++++++
 tb/tb_axi_probe_ram.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_probe_pkg.sv
// rtl/axi_probe_pkg.sv - shared response codes, FSM encodings and address decode for the probe RAM
package axi_probe_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_RESP
  } w_state_e;

  // Window check is done on a 33-bit offset so a 4 GiB window cannot overflow.
  function automatic logic [1:0] decode_resp(input logic [31:0] addr,
                                             input logic [31:0] base,
                                             input int unsigned depth_log2);
    logic [32:0] off;
    logic [32:0] win;
    off = {1'b0, addr - base};
    win = 33'd4 << depth_log2;
    if (off >= win) begin
      return RESP_DECERR;
    end else if (addr[1:0] != 2'b00) begin
      return RESP_SLVERR;
    end
    return RESP_OKAY;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// rtl/sdp_ram.sv - simple dual-port word RAM: one registered read port, one byte-enabled write port
module sdp_ram #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rd_en_i,
  input  logic [DEPTH_LOG2-1:0] rd_addr_i,
  output logic [31:0]           rd_data_o,
  input  logic                  wr_en_i,
  input  logic [DEPTH_LOG2-1:0] wr_addr_i,
  input  logic [31:0]           wr_data_i,
  input  logic [3:0]            wr_strb_i
);

  logic [31:0] mem_q [2**DEPTH_LOG2];
  logic [31:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_strb_i[i]) begin
          mem_q[wr_addr_i][8*i +: 8] <= wr_data_i[8*i +: 8];
        end
      end
    end
  end

  // A read colliding with a write on the same edge sees the old word.
  always_ff @(posedge clk) begin
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axi_probe_ram.sv
// rtl/axi_probe_ram.sv - AXI-lite-style responder terminating the probe master onto an SRAM window
module axi_probe_ram
  import axi_probe_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
  parameter int          DEPTH_LOG2 = 8
) (
  input  logic        clk,
  input  logic        s_areset,
  input  logic [31:0] s_axi_araddr,
  input  logic [2:0]  s_axi_arsize,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  input  logic [31:0] s_axi_awaddr,
  input  logic [2:0]  s_axi_awsize,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  output logic [7:0]  err_count
);

  r_state_e               r_state_q;
  w_state_e               w_state_q;
  logic [1:0]             rresp_q;
  logic [1:0]             bresp_q;
  logic [DEPTH_LOG2-1:0]  widx_q;
  logic [31:0]            wdata_q;
  logic [3:0]             wstrb_q;
  logic [7:0]             err_q;
  logic [7:0]             err_d;

  logic [31:0]            ar_off;
  logic [31:0]            aw_off;
  logic [DEPTH_LOG2-1:0]  ar_idx;
  logic [DEPTH_LOG2-1:0]  aw_idx;
  logic [1:0]             ar_resp;
  logic [1:0]             aw_resp;
  logic                   ar_fire;
  logic [31:0]            ram_rdata;

  logic                   wr_en;
  logic [DEPTH_LOG2-1:0]  wr_idx;
  logic [31:0]            wr_data;
  logic [3:0]             wr_strb;

  logic                   r_err;
  logic                   b_err;
  logic [8:0]             err_sum;
  logic                   unused_bits;

  assign ar_off  = s_axi_araddr - ADDR_BASE;
  assign aw_off  = s_axi_awaddr - ADDR_BASE;
  assign ar_idx  = ar_off[DEPTH_LOG2+1:2];
  assign aw_idx  = aw_off[DEPTH_LOG2+1:2];
  assign ar_resp = decode_resp(s_axi_araddr, ADDR_BASE, DEPTH_LOG2);
  assign aw_resp = decode_resp(s_axi_awaddr, ADDR_BASE, DEPTH_LOG2);
  assign unused_bits = ^{s_axi_arsize, s_axi_awsize,
                         ar_off[31:DEPTH_LOG2+2], ar_off[1:0],
                         aw_off[31:DEPTH_LOG2+2], aw_off[1:0]};

  assign ar_fire = (r_state_q == R_IDLE) && s_axi_arvalid;

  always_ff @(posedge clk) begin
    if (s_areset) begin
      r_state_q <= R_IDLE;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (s_axi_arvalid) begin
            rresp_q   <= ar_resp;
            r_state_q <= R_RESP;
          end
        end
        R_RESP: begin
          if (s_axi_rready) begin
            r_state_q <= R_IDLE;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  // Memory commit happens on the edge that captures the later of AW and W.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = aw_idx;
    wr_data = s_axi_wdata;
    wr_strb = s_axi_wstrb;
    case (w_state_q)
      W_IDLE:    wr_en = s_axi_awvalid && s_axi_wvalid && (aw_resp == RESP_OKAY);
      W_HAVE_AW: begin
        wr_idx = widx_q;
        wr_en  = s_axi_wvalid && (bresp_q == RESP_OKAY);
      end
      W_HAVE_W:  begin
        wr_data = wdata_q;
        wr_strb = wstrb_q;
        wr_en   = s_axi_awvalid && (aw_resp == RESP_OKAY);
      end
      default:   wr_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (s_areset) begin
      w_state_q <= W_IDLE;
      bresp_q   <= RESP_OKAY;
      widx_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (s_axi_awvalid && s_axi_wvalid) begin
            bresp_q   <= aw_resp;
            w_state_q <= W_RESP;
          end else if (s_axi_awvalid) begin
            bresp_q   <= aw_resp;
            widx_q    <= aw_idx;
            w_state_q <= W_HAVE_AW;
          end else if (s_axi_wvalid) begin
            wdata_q   <= s_axi_wdata;
            wstrb_q   <= s_axi_wstrb;
            w_state_q <= W_HAVE_W;
          end
        end
        W_HAVE_AW: begin
          if (s_axi_wvalid) begin
            w_state_q <= W_RESP;
          end
        end
        W_HAVE_W: begin
          if (s_axi_awvalid) begin
            bresp_q   <= aw_resp;
            w_state_q <= W_RESP;
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  sdp_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk       (clk),
    .rd_en_i   (ar_fire),
    .rd_addr_i (ar_idx),
    .rd_data_o (ram_rdata),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_idx),
    .wr_data_i (wr_data),
    .wr_strb_i (wr_strb)
  );

  assign s_axi_arready = (r_state_q == R_IDLE);
  assign s_axi_rvalid  = (r_state_q == R_RESP);
  assign s_axi_rresp   = s_axi_rvalid ? rresp_q : RESP_OKAY;
  assign s_axi_rdata   = (s_axi_rvalid && (rresp_q == RESP_OKAY)) ? ram_rdata : 32'h0;

  assign s_axi_awready = (w_state_q == W_IDLE) || (w_state_q == W_HAVE_W);
  assign s_axi_wready  = (w_state_q == W_IDLE) || (w_state_q == W_HAVE_AW);
  assign s_axi_bvalid  = (w_state_q == W_RESP);
  assign s_axi_bresp   = s_axi_bvalid ? bresp_q : RESP_OKAY;

  assign r_err   = s_axi_rvalid && s_axi_rready && (rresp_q != RESP_OKAY);
  assign b_err   = s_axi_bvalid && s_axi_bready && (bresp_q != RESP_OKAY);
  assign err_sum = {1'b0, err_q} + {8'd0, r_err} + {8'd0, b_err};
  assign err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];

  always_ff @(posedge clk) begin
    if (s_areset) begin
      err_q <= 8'h00;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_count = err_q;

endmodule

// File: tb/tb_axi_probe_ram.sv
// tb/tb_axi_probe_ram.sv - scoreboard bench for axi_probe_ram with a word-array reference model
module tb_axi_probe_ram;

  localparam logic [31:0] BASE  = 32'h4000_0000;
  localparam int          DL    = 8;
  localparam int          WORDS = 256;
  localparam logic [31:0] WIN   = 32'd1024;

  logic        clk = 1'b0;
  logic        s_areset = 1'b1;
  logic [31:0] araddr = '0;
  logic [2:0]  arsize = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] awaddr = '0;
  logic [2:0]  awsize = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  axi_probe_ram #(
    .ADDR_BASE (BASE),
    .DEPTH_LOG2(DL)
  ) dut (
    .clk          (clk),
    .s_areset     (s_areset),
    .s_axi_araddr (araddr),
    .s_axi_arsize (arsize),
    .s_axi_arvalid(arvalid),
    .s_axi_arready(arready),
    .s_axi_rdata  (rdata),
    .s_axi_rresp  (rresp),
    .s_axi_rvalid (rvalid),
    .s_axi_rready (rready),
    .s_axi_awaddr (awaddr),
    .s_axi_awsize (awsize),
    .s_axi_awvalid(awvalid),
    .s_axi_awready(awready),
    .s_axi_wdata  (wdata),
    .s_axi_wstrb  (wstrb),
    .s_axi_wvalid (wvalid),
    .s_axi_wready (wready),
    .s_axi_bresp  (bresp),
    .s_axi_bvalid (bvalid),
    .s_axi_bready (bready),
    .err_count    (err_count)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  rexp_t       rq[$];
  logic [1:0]  bq[$];
  logic [31:0] model [WORDS];
  int          exp_err = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  bit          mon_en = 1'b0;
  rexp_t       mon_e;
  logic [1:0]  mon_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [1:0] ref_resp(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    if (off >= WIN) return 2'b11;
    if (addr % 4 != 0) return 2'b10;
    return 2'b00;
  endfunction

  function automatic int ref_idx(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    return int'(off / 4) % WORDS;
  endfunction

  function automatic void model_write(input logic [31:0] addr, input logic [31:0] d,
                                      input logic [3:0] s);
    int k;
    if (ref_resp(addr) != 2'b00) return;
    k = ref_idx(addr);
    for (int b = 0; b < 4; b++)
      if (s[b]) model[k][8*b +: 8] = d[8*b +: 8];
  endfunction

  function automatic rexp_t read_exp(input logic [31:0] addr);
    rexp_t e;
    e.resp = ref_resp(addr);
    e.data = (e.resp == 2'b00) ? model[ref_idx(addr)] : 32'h0;
    return e;
  endfunction

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 6) return BASE + 4 * $urandom_range(0, WORDS - 1);
    if (r == 7) return BASE + 4 * $urandom_range(0, WORDS - 1) + $urandom_range(1, 3);
    if (r == 8) return BASE + WIN + $urandom_range(0, 4000);
    return BASE - $urandom_range(1, 400);
  endfunction

  // Scoreboard monitor: pops expectations on every R/B handshake, tracks err_count.
  always @(negedge clk) begin
    if (mon_en) begin
      check("err_count", {24'd0, err_count}, exp_err);
      if (s_areset) begin
        exp_err = 0;
      end else begin
        if (rvalid && rready) begin
          if (rq.size() == 0) begin
            n_checks++;
            $display("FAIL extra_r: got rdata %h with no read outstanding", rdata);
          end else begin
            mon_e = rq.pop_front();
            check("rdata", rdata, mon_e.data);
            check("rresp", {30'd0, rresp}, {30'd0, mon_e.resp});
            if (mon_e.resp != 2'b00) exp_err = (exp_err < 255) ? exp_err + 1 : 255;
          end
        end
        if (bvalid && bready) begin
          if (bq.size() == 0) begin
            n_checks++;
            $display("FAIL extra_b: got bresp %h with no write outstanding", bresp);
          end else begin
            mon_b = bq.pop_front();
            check("bresp", {30'd0, bresp}, {30'd0, mon_b});
            if (mon_b != 2'b00) exp_err = (exp_err < 255) ? exp_err + 1 : 255;
          end
        end
      end
    end
  end

  task automatic do_read(input logic [31:0] addr, input int hold);
    rexp_t e;
    int    t;
    e = read_exp(addr);
    rq.push_back(e);
    @(posedge clk); #1;
    araddr  = addr;
    arsize  = 3'($urandom);
    arvalid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!arready && t < 50);
    check("ar_accept", {31'd0, arready}, 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    check("rvalid_lat", {31'd0, rvalid}, 32'd1);
    check("arready_busy", {31'd0, arready}, 32'd0);
    repeat (hold) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("hold_rvalid", {31'd0, rvalid}, 32'd1);
      check("hold_rdata", rdata, e.data);
      check("hold_rresp", {30'd0, rresp}, {30'd0, e.resp});
      check("hold_arready", {31'd0, arready}, 32'd0);
    end
    @(posedge clk); #1;
    rready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    rready = 1'b0;
    @(negedge clk);
    check("r_done", {31'd0, rvalid}, 32'd0);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s,
                          input int t_aw, input int t_w, input int bhold);
    bit aw_done, w_done, aw_hs, w_hs, w_first, aw_first;
    int c;
    bq.push_back(ref_resp(addr));
    model_write(addr, d, s);
    aw_done = 0; w_done = 0; w_first = 0; aw_first = 0; c = 0;
    @(posedge clk); #1;
    while (!(aw_done && w_done) && c < 60) begin
      if (c == t_aw) begin
        awaddr = addr; awsize = 3'($urandom); awvalid = 1'b1;
      end
      if (c == t_w) begin
        wdata = d; wstrb = s; wvalid = 1'b1;
      end
      @(negedge clk);
      if (w_first)  check("wready_drop", {31'd0, wready}, 32'd0);
      if (aw_first) check("awready_drop", {31'd0, awready}, 32'd0);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_hs) begin awvalid = 1'b0; aw_done = 1; end
      if (w_hs)  begin wvalid = 1'b0; w_done = 1; end
      w_first  = w_done && !aw_done;
      aw_first = aw_done && !w_done;
      c++;
    end
    check("aw_w_accept", {30'd0, aw_done, w_done}, 32'd3);
    @(negedge clk);
    check("bvalid_lat", {31'd0, bvalid}, 32'd1);
    repeat (bhold) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("hold_bvalid", {31'd0, bvalid}, 32'd1);
      check("hold_bresp", {30'd0, bresp}, {30'd0, ref_resp(addr)});
    end
    @(posedge clk); #1;
    bready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bready = 1'b0;
    @(negedge clk);
    check("b_single", {31'd0, bvalid}, 32'd0);
  endtask

  // AR handshake and write commit land on the same edge.
  task automatic concurrent(input logic [31:0] waddr, input logic [31:0] d, input logic [31:0] raddr);
    rq.push_back(read_exp(raddr));
    bq.push_back(ref_resp(waddr));
    model_write(waddr, d, 4'hF);
    @(posedge clk); #1;
    awaddr = waddr; awvalid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    awvalid = 1'b0;
    wdata = d; wstrb = 4'hF; wvalid = 1'b1;
    araddr = raddr; arvalid = 1'b1;
    @(negedge clk);
    check("conc_ready", {30'd0, arready, wready}, 32'd3);
    @(posedge clk); #1;
    wvalid = 1'b0; arvalid = 1'b0;
    rready = 1'b1; bready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    rready = 1'b0; bready = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int mode, ta, tw;
    logic [31:0] a;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_bvalid", {31'd0, bvalid}, 32'd0);
    check("rst_readies", {29'd0, arready, awready, wready}, 32'd7);
    check("rst_rdata", rdata, 32'd0);
    check("rst_resps", {28'd0, rresp, bresp}, 32'd0);
    check("rst_err", {24'd0, err_count}, 32'd0);
    @(posedge clk); #1;
    s_areset = 1'b0;
    mon_en = 1'b1;

    for (int k = 0; k < WORDS; k++) do_write(BASE + 4 * k, $urandom, 4'hF, 0, 0, 0);

    do_write(BASE + 8, 32'hCAFE_F00D, 4'hF, 0, 0, 0);
    do_read(BASE + 8, 0);
    do_write(BASE + 12, 32'h1357_9BDF, 4'hF, 3, 0, 1);
    do_read(BASE + 12, 0);
    do_write(BASE + 16, 32'h2468_ACE0, 4'hF, 0, 3, 0);
    do_read(BASE + 16, 0);
    do_write(BASE + 40, 32'h1122_3344, 4'hF, 0, 0, 0);
    do_write(BASE + 40, 32'hAAAA_AAAA, 4'b0101, 0, 0, 0);
    do_read(BASE + 40, 0);
    do_read(BASE + WIN, 0);
    do_read(BASE + 2, 0);
    check("err_two", {24'd0, err_count}, 32'd2);
    do_read(BASE + 40, 5);

    concurrent(BASE + 80, 32'h5A5A_0F0F, BASE + 80);
    do_read(BASE + 80, 0);
    concurrent(BASE - 4, 32'hDEAD_BEEF, BASE + 1026);

    @(posedge clk); #1;
    awaddr = BASE + 120; awvalid = 1'b1; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
    @(negedge clk);
    check("rst_aw_acc", {31'd0, awready}, 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; s_areset = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    s_areset = 1'b0;
    @(negedge clk);
    check("mid_rst_bvalid", {31'd0, bvalid}, 32'd0);
    check("mid_rst_ready", {30'd0, awready, wready}, 32'd3);
    check("mid_rst_err", {24'd0, err_count}, 32'd0);
    do_read(BASE + 120, 0);

    for (int n = 0; n < 300; n++) begin
      a = rand_addr();
      if ($urandom_range(0, 1) == 0) begin
        do_read(a, $urandom_range(0, 3));
      end else begin
        mode = $urandom_range(0, 2);
        ta = (mode == 2) ? $urandom_range(1, 3) : 0;
        tw = (mode == 1) ? $urandom_range(1, 3) : 0;
        do_write(a, $urandom, 4'($urandom), ta, tw, $urandom_range(0, 3));
      end
    end

    for (int n = 0; n < 260; n++) do_read(BASE + WIN + 4 * n, 0);
    check("err_sat", {24'd0, err_count}, 32'd255);

    repeat (3) @(posedge clk);
    check("rq_empty", rq.size(), 32'd0);
    check("bq_empty", bq.size(), 32'd0);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
